// File: rtl/kbd_pkg.sv
// Shared types and default sizing for the keyboard event scheduler.
package kbd_pkg;

    // One key event in the order the matrix expects its fields.
    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } kbd_sched_state_t;

    localparam int KBD_FIFO_DEPTH = 8;
    localparam int KBD_MIN_GAP    = 50000;
    localparam int KBD_GAP_W      = 17;

endpackage

// File: rtl/kbd_event_fifo.sv
// Circular event buffer with wrap-around pointers and an occupancy count.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = KBD_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  kbd_event_t       push_data,
    input  logic             pop,
    output kbd_event_t       pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    kbd_event_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    // Next pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Event storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count define which entries are valid.
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/kbd_event_sched.sv
// Merges PS/2 and injector key events into one paced toggle-strobe stream.
module kbd_event_sched
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = KBD_FIFO_DEPTH,
    parameter int MIN_GAP    = KBD_MIN_GAP,
    parameter int GAP_W      = KBD_GAP_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_strobe,
    input  logic       ps2_pressed,
    input  logic       ps2_extended,
    input  logic [7:0] ps2_code,
    input  logic       inj_valid,
    output logic       inj_ready,
    input  logic       inj_pressed,
    input  logic       inj_extended,
    input  logic [7:0] inj_code,
    output logic       out_strobe,
    output logic       out_pressed,
    output logic       out_extended,
    output logic [7:0] out_code,
    output logic       busy,
    output logic       overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    kbd_sched_state_t state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             strobe_q, strobe_d;
    kbd_event_t       out_ev_q, out_ev_d;
    logic             overflow_q, overflow_d;
    logic             ps2_prev_q, ps2_prev_d;

    logic             ps2_evt;
    logic             push, pop;
    kbd_event_t       push_data, head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             inj_room;

    kbd_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The last free slot is kept for PS/2, which cannot be back-pressured.
    assign ps2_evt    = ~reset & (ps2_strobe != ps2_prev_q);
    assign ps2_prev_d = ps2_strobe;
    assign inj_room   = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(2);
    assign inj_ready  = ~reset & inj_room & ~ps2_evt;

    // Arbitration: PS/2 wins; a PS/2 event finding the FIFO full is dropped and flagged.
    always_comb begin
        push       = 1'b0;
        push_data  = '0;
        overflow_d = overflow_q;
        if (ps2_evt) begin
            if (!fifo_full) begin
                push      = 1'b1;
                push_data = '{pressed: ps2_pressed, extended: ps2_extended, code: ps2_code};
            end else begin
                overflow_d = 1'b1;
            end
        end else if (inj_valid && inj_ready) begin
            push      = 1'b1;
            push_data = '{pressed: inj_pressed, extended: inj_extended, code: inj_code};
        end
    end

    // Emission FSM: pop and toggle from IDLE, then count out the minimum gap.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        strobe_d = strobe_q;
        out_ev_d = out_ev_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    out_ev_d = head;
                    strobe_d = ~strobe_q;
                    gap_d    = GAP_W'(MIN_GAP - 1);
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scheduler registers; the strobe history tracks the input during reset to avoid a false event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            strobe_q   <= 1'b0;
            out_ev_q   <= '0;
            overflow_q <= 1'b0;
            ps2_prev_q <= ps2_strobe;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            strobe_q   <= strobe_d;
            out_ev_q   <= out_ev_d;
            overflow_q <= overflow_d;
            ps2_prev_q <= ps2_prev_d;
        end
    end

    assign out_strobe   = strobe_q;
    assign out_pressed  = out_ev_q.pressed;
    assign out_extended = out_ev_q.extended;
    assign out_code     = out_ev_q.code;
    assign overflow     = overflow_q;
    assign busy         = (state_q != S_IDLE) | ~fifo_empty;

endmodule
